mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Parametrised N-port memory arbiter.
- Lets NUM_PORTS requesters share one memory port, for example the imem/dmem ports of one or more cores.
- Round-robin grant with grant lock under back-pressure; up to MAX_OUTSTANDING in-flight requests.
- Responses return in order and are routed by an internal grant-ID FIFO.

Parameters:
- NUM_PORTS, 2, number of requester channels (2..8).
- ADDR_W, 32, address width.
- DATA_W, 32, data width; wstrb width is DATA_W/8.
- MAX_OUTSTANDING, 4, ID FIFO depth; power of two, 1..16.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_PORTS  per-port request valid.
- req_ready  out  NUM_PORTS  per-port request accepted.
- req_addr  in  NUM_PORTS*ADDR_W  packed addresses; port i in slice [i*ADDR_W +: ADDR_W].
- req_we  in  NUM_PORTS  write enable.
- req_wdata  in  NUM_PORTS*DATA_W  packed write data.
- req_wstrb  in  NUM_PORTS*DATA_W/8  packed byte strobes.
- resp_valid  out  NUM_PORTS  one-cycle response pulse to the owning port.
- resp_rdata  out  DATA_W  response data, broadcast to all ports.
- mem_req_valid  out  1  request to memory.
- mem_req_ready  in  1  memory accepts request.
- mem_addr / mem_we / mem_wdata / mem_wstrb  out  ADDR_W / 1 / DATA_W / DATA_W/8  muxed request payload.
- mem_resp_valid  in  1  memory response (reads and write acks), in order, no back-pressure.
- mem_resp_rdata  in  DATA_W  response data.
- outstanding  out  $clog2(MAX_OUTSTANDING+1)  in-flight count.
- err_unexpected_resp  out  1  sticky error flag.

Behaviour:
- Reset (async, active-high): rr_ptr=0, lock=0, ID FIFO empty, outstanding=0, err_unexpected_resp=0. All outputs are 0 while reset is asserted.
- Port selection:
  - can_issue = (outstanding < MAX_OUTSTANDING). There is no bypass: a response arriving in the same cycle does not free a slot for that cycle's issue.
  - If lock=1, sel = locked_id.
  - Otherwise sel = first i with req_valid[i]=1, scanning from rr_ptr upward and wrapping modulo NUM_PORTS.
- Request path:
  - mem_req_valid = can_issue & req_valid[sel].
  - mem payload = slice sel, combinational, zero added latency.
  - req_ready[i] = (i==sel) & can_issue & mem_req_ready; all other bits are 0.
- Grant lock:
  - If mem_req_valid & !mem_req_ready: lock<=1, locked_id<=sel.
  - A higher-priority valid arriving later must not change sel while locked.
  - Requesters must hold valid and payload until ready.
- Handshake (mem_req_valid & mem_req_ready):
  - Push sel into the ID FIFO.
  - rr_ptr <= (sel+1) mod NUM_PORTS.
  - lock <= 0.
- Response:
  - On mem_resp_valid with the FIFO non-empty: pop head h; resp_valid[h]=1 in the same cycle (combinational); resp_rdata = mem_resp_rdata.
  - resp_valid has at most one bit set in any cycle.
- outstanding:
  - +1 on handshake, -1 on pop, unchanged when both occur in one cycle.
  - Never exceeds MAX_OUTSTANDING and never underflows.
- Unexpected response: mem_resp_valid with the FIFO empty drops the response (no resp_valid) and sets err_unexpected_resp=1. The flag stays set until reset.
- FIFO pointers wrap modulo MAX_OUTSTANDING.
- Mid-operation reset: all in-flight IDs and any lock are discarded. Responses arriving after reset are treated as unexpected.

Test Plan:
- NUM_PORTS=2, both ports valid continuously, mem_req_ready=1, each response 2 cycles after its request → grants alternate 0,1,0,1. resp_valid pulses arrive in the same order; outstanding stays at or below 2.
- Port 0 valid, mem_req_ready=0 for 3 cycles, port 1 raises valid in cycle 1 → sel stays 0 and mem_addr stays at port 0's address. Port 0 handshakes in cycle 3; port 1 is granted next.
- MAX_OUTSTANDING=4, 4 requests accepted with no responses → outstanding=4 and mem_req_valid=0. A response arriving in cycle t frees a slot; issue resumes in cycle t+1.
- Response in the same cycle as a handshake with outstanding=2 → outstanding stays 2. The popped ID is the oldest.
- mem_resp_valid=1 with rdata=0xDEADBEEF and the FIFO empty → no resp_valid; err_unexpected_resp=1 and stays 1.
- Reset asserted with outstanding=3 and lock=1 → all outputs 0 immediately, outstanding=0. After release, the first grant starts scanning from port 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// N-port round-robin memory arbiter with grant lock under back-pressure and
// an in-order grant-ID FIFO that routes responses back to their requesters.
module mem_port_arbiter #(
    parameter int NUM_PORTS       = 2,
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [NUM_PORTS-1:0]                   req_valid,
    output logic [NUM_PORTS-1:0]                   req_ready,
    input  logic [NUM_PORTS*ADDR_W-1:0]            req_addr,
    input  logic [NUM_PORTS-1:0]                   req_we,
    input  logic [NUM_PORTS*DATA_W-1:0]            req_wdata,
    input  logic [NUM_PORTS*DATA_W/8-1:0]          req_wstrb,
    output logic [NUM_PORTS-1:0]                   resp_valid,
    output logic [DATA_W-1:0]                      resp_rdata,
    output logic                                   mem_req_valid,
    input  logic                                   mem_req_ready,
    output logic [ADDR_W-1:0]                      mem_addr,
    output logic                                   mem_we,
    output logic [DATA_W-1:0]                      mem_wdata,
    output logic [DATA_W/8-1:0]                    mem_wstrb,
    input  logic                                   mem_resp_valid,
    input  logic [DATA_W-1:0]                      mem_resp_rdata,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding,
    output logic                                   err_unexpected_resp
);

    localparam int ID_W   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int PTR_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam int STRB_W = DATA_W / 8;

    logic [ID_W-1:0]  rr_ptr;
    logic             lock;
    logic [ID_W-1:0]  locked_id;
    logic [ID_W-1:0]  scan_sel;
    logic [ID_W-1:0]  sel;
    logic [ID_W-1:0]  id_fifo [MAX_OUTSTANDING];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [ID_W-1:0]  head;
    logic             can_issue;
    logic             handshake;
    logic             pop;
    logic             fifo_empty;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    // Round-robin scan: first valid port at or after rr_ptr, wrapping.
    always_comb begin
        int unsigned idx;
        logic        found;
        idx      = 0;
        found    = 1'b0;
        scan_sel = rr_ptr;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            idx = 32'(rr_ptr) + k;
            if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
            if (!found && req_valid[ID_W'(idx)]) begin
                found    = 1'b1;
                scan_sel = ID_W'(idx);
            end
        end
    end

    assign sel        = lock ? locked_id : scan_sel;
    assign can_issue  = (outstanding < CNT_W'(MAX_OUTSTANDING));
    assign fifo_empty = (outstanding == '0);
    assign head       = id_fifo[rd_ptr];

    assign mem_req_valid = !reset && can_issue && req_valid[sel];
    assign handshake     = mem_req_valid && mem_req_ready;
    assign pop           = !reset && mem_resp_valid && !fifo_empty;
    assign resp_rdata    = reset ? '0 : mem_resp_rdata;

    always_comb begin
        mem_addr   = '0;
        mem_we     = 1'b0;
        mem_wdata  = '0;
        mem_wstrb  = '0;
        req_ready  = '0;
        resp_valid = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (!reset && ID_W'(i) == sel) begin
                mem_addr     = req_addr[i*ADDR_W +: ADDR_W];
                mem_we       = req_we[i];
                mem_wdata    = req_wdata[i*DATA_W +: DATA_W];
                mem_wstrb    = req_wstrb[i*STRB_W +: STRB_W];
                req_ready[i] = can_issue && mem_req_ready;
            end
            if (pop && ID_W'(i) == head) resp_valid[i] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr              <= '0;
            lock                <= 1'b0;
            locked_id           <= '0;
            rd_ptr              <= '0;
            wr_ptr              <= '0;
            outstanding         <= '0;
            err_unexpected_resp <= 1'b0;
        end else begin
            if (handshake) begin
                rr_ptr <= (sel == ID_W'(NUM_PORTS - 1)) ? '0 : sel + 1'b1;
                lock   <= 1'b0;
                wr_ptr <= ptr_inc(wr_ptr);
            end else if (mem_req_valid) begin
                lock      <= 1'b1;
                locked_id <= sel;
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            // Simultaneous push and pop leaves the in-flight count unchanged.
            if (handshake && !pop)
                outstanding <= outstanding + CNT_W'(1);
            else if (pop && !handshake)
                outstanding <= outstanding - CNT_W'(1);
            if (mem_resp_valid && fifo_empty) err_unexpected_resp <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (handshake) id_fifo[wr_ptr] <= sel;
    end

endmodule
